// File: rtl/cpu_pkg.sv
// Shared front-end control definitions: PC redirect select encodings and
// the interrupt-acceptance FSM state type.
package cpu_pkg;

    localparam logic [2:0] PCSRC_EXC  = 3'b000;
    localparam logic [2:0] PCSRC_IRQ  = 3'b001;
    localparam logic [2:0] PCSRC_JIMM = 3'b010;
    localparam logic [2:0] PCSRC_JREG = 3'b011;
    localparam logic [2:0] PCSRC_SEQ  = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ENTER  = 2'd2,
        KERNEL = 2'd3
    } irq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the EX load and the ID consumer.
// Kept standalone so the forwarding unit can share it.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             luh
);

    // Register zero is hardwired, so a load into it never creates a hazard.
    assign luh = ex_memread && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbitration for the IF/ID front end, with the interrupt
// acceptance FSM that only admits an IRQ at a safe point in user mode.
module pc_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter int LAT_W = 8,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IRQ,
    input  logic             PC31,
    input  logic             id_undef,
    input  logic             id_jump_imm,
    input  logic             id_jump_reg,
    input  logic             id_branch_taken,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    output logic [2:0]       PCSrc,
    output logic             stall,
    output logic             isJump,
    output logic             isBranch,
    output logic             epc_we,
    output logic [LAT_W-1:0] irq_latency
);

    irq_state_e       state_q;
    logic             shadow_q;
    logic [LAT_W-1:0] lat_q;

    logic luh;
    logic exc;
    logic irq_fire;
    logic irq_ok;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .luh        (luh)
    );

    // Undefined instructions in kernel mode are ignored rather than trapped.
    assign exc      = id_undef && !PC31;
    assign irq_fire = (state_q == ENTER) && !PC31;

    assign irq_ok = IRQ && !PC31 && !shadow_q && !luh && !id_undef &&
                    !id_jump_imm && !id_jump_reg && !id_branch_taken;

    always_comb begin
        PCSrc    = PCSRC_SEQ;
        stall    = 1'b0;
        isJump   = 1'b0;
        isBranch = 1'b0;
        epc_we   = 1'b0;
        if (exc) begin
            PCSrc  = PCSRC_EXC;
            epc_we = 1'b1;
        end else if (irq_fire) begin
            PCSrc  = PCSRC_IRQ;
            epc_we = 1'b1;
        end else if (luh) begin
            stall = 1'b1;
        end else if (id_jump_reg) begin
            PCSrc  = PCSRC_JREG;
            isJump = 1'b1;
        end else if (id_jump_imm) begin
            PCSrc  = PCSRC_JIMM;
            isJump = 1'b1;
        end else if (id_branch_taken) begin
            isBranch = 1'b1;
        end
    end

    assign irq_latency = lat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= 1'b0;
            lat_q    <= '0;
        end else begin
            shadow_q <= isJump || isBranch || exc;
            case (state_q)
                IDLE: begin
                    if (IRQ && !PC31) begin
                        state_q <= WAIT;
                        lat_q   <= '0;
                    end
                end
                WAIT: begin
                    if (!(&lat_q)) lat_q <= lat_q + LAT_W'(1);
                    if (!IRQ || PC31)  state_q <= IDLE;
                    else if (irq_ok)   state_q <= ENTER;
                end
                // A colliding exception defers entry; once PC31 is set the entry is dropped.
                ENTER: begin
                    if (!exc) state_q <= KERNEL;
                end
                KERNEL: begin
                    if (!PC31) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: redirect priority, load-use stall,
// interrupt acceptance timing, latency saturation and asynchronous reset.
module tb_pc_redirect_ctrl;

    localparam int LAT_W = 4;
    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             IRQ, PC31, id_undef, id_jump_imm, id_jump_reg, id_branch_taken;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread;
    logic [2:0]       PCSrc;
    logic             stall, isJump, isBranch, epc_we;
    logic [LAT_W-1:0] irq_latency;

    int total = 0;
    int fails = 0;

    pc_redirect_ctrl #(.LAT_W(LAT_W), .REG_W(REG_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .IRQ             (IRQ),
        .PC31            (PC31),
        .id_undef        (id_undef),
        .id_jump_imm     (id_jump_imm),
        .id_jump_reg     (id_jump_reg),
        .id_branch_taken (id_branch_taken),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .PCSrc           (PCSrc),
        .stall           (stall),
        .isJump          (isJump),
        .isBranch        (isBranch),
        .epc_we          (epc_we),
        .irq_latency     (irq_latency)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ev(input logic [2:0] p, input logic s, input logic j,
                                       input logic b, input logic e);
        ev = {25'd0, p, s, j, b, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Outputs packed as {PCSrc, stall, isJump, isBranch, epc_we}.
    task automatic co(input string tag, input logic [31:0] exp_v);
        #1;
        chk(tag, {25'd0, PCSrc, stall, isJump, isBranch, epc_we}, exp_v);
    endtask

    task automatic chk_lat(input string tag, input int exp_v);
        chk(tag, {28'd0, irq_latency}, exp_v);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        IRQ = 0; PC31 = 0; id_undef = 0; id_jump_imm = 0; id_jump_reg = 0;
        id_branch_taken = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_memread = 0; ex_rt = 0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        #12;
        co("rst_out", ev(3'b100, 0, 0, 0, 0));
        chk_lat("rst_lat", 0);
        reset = 1'b0;
        cyc();

        // Load-use stall
        ex_memread = 1; ex_rt = 8; id_rs = 8;
        co("luh_c1", ev(3'b100, 1, 0, 0, 0));
        cyc();
        co("luh_c2", ev(3'b100, 1, 0, 0, 0));
        cyc();
        ex_memread = 0;
        co("luh_off", ev(3'b100, 0, 0, 0, 0));
        cyc();
        ex_memread = 1; ex_rt = 9; id_rs = 1; id_rt = 9; id_uses_rt = 1;
        co("luh_rt", ev(3'b100, 1, 0, 0, 0));
        id_uses_rt = 0;
        co("luh_rt_unused", ev(3'b100, 0, 0, 0, 0));
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
        co("luh_r0", ev(3'b100, 0, 0, 0, 0));
        ex_rt = 8; id_rs = 8; id_jump_imm = 1;
        co("luh_over_jmp", ev(3'b100, 1, 0, 0, 0));
        cyc();
        clr();

        // Jumps, branches, exceptions
        id_jump_imm = 1;
        co("jimm", ev(3'b010, 0, 1, 0, 0));
        cyc();
        clr();
        id_branch_taken = 1;
        co("branch", ev(3'b100, 0, 0, 1, 0));
        cyc();
        clr();
        PC31 = 1; id_undef = 1; id_jump_imm = 1;
        co("undef_kernel", ev(3'b010, 0, 1, 0, 0));
        PC31 = 0;
        co("exc_user", ev(3'b000, 0, 0, 0, 1));
        cyc();
        clr();

        // IRQ on an idle pipeline: WAIT, ENTER, KERNEL
        IRQ = 1;
        co("irq_idle", ev(3'b100, 0, 0, 0, 0));
        cyc();
        co("irq_wait", ev(3'b100, 0, 0, 0, 0));
        chk_lat("lat_wait", 0);
        cyc();
        co("irq_enter", ev(3'b001, 0, 0, 0, 1));
        chk_lat("lat_enter", 1);
        cyc();
        PC31 = 1;
        co("irq_kernel", ev(3'b100, 0, 0, 0, 0));
        id_undef = 1;
        co("kern_undef", ev(3'b100, 0, 0, 0, 0));
        cyc();
        chk_lat("lat_held", 1);
        clr();
        cyc();

        // jr with branch_taken, IRQ raised in the same cycle
        IRQ = 1; id_jump_reg = 1; id_branch_taken = 1;
        co("jr_bt", ev(3'b011, 0, 1, 0, 0));
        cyc();
        id_jump_reg = 0; id_branch_taken = 0;
        co("wait_shadow", ev(3'b100, 0, 0, 0, 0));
        cyc();
        co("wait_clear", ev(3'b100, 0, 0, 0, 0));
        chk_lat("lat_jr_wait", 1);
        cyc();

        // Exception collides with ENTER
        id_undef = 1;
        co("exc_enter", ev(3'b000, 0, 0, 0, 1));
        chk_lat("lat_jr_enter", 2);
        cyc();
        id_undef = 0;
        co("enter_after_exc", ev(3'b001, 0, 0, 0, 1));
        cyc();
        PC31 = 1;
        co("kern_after_exc", ev(3'b100, 0, 0, 0, 0));
        cyc();
        clr();
        cyc();

        // Latency saturation under a continuous load-use stall
        IRQ = 1; ex_memread = 1; ex_rt = 8; id_rs = 8;
        cyc();
        repeat (20) cyc();
        co("sat_stall", ev(3'b100, 1, 0, 0, 0));
        chk_lat("lat_sat", 15);
        repeat (5) cyc();
        chk_lat("lat_nowrap", 15);

        // Asynchronous reset mid-WAIT
        #3 reset = 1'b1;
        #1 chk_lat("rst_wait_lat", 0);
        clr();
        co("rst_wait_out", ev(3'b100, 0, 0, 0, 0));
        reset = 1'b0;
        cyc();

        // Asynchronous reset mid-ENTER
        IRQ = 1;
        cyc();
        cyc();
        co("enter_pre_rst", ev(3'b001, 0, 0, 0, 1));
        #3 reset = 1'b1;
        co("rst_enter_out", ev(3'b100, 0, 0, 0, 0));
        chk_lat("rst_enter_lat", 0);
        reset = 1'b0;
        cyc();
        co("wait_post_rst", ev(3'b100, 0, 0, 0, 0));
        cyc();
        co("enter_post_rst", ev(3'b001, 0, 0, 0, 1));
        chk_lat("lat_post_rst", 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
